// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: walks one captured ALU instruction through the
// shared-bus strobe sequence and reports completion with a done/err pulse.
module alu_seq_fsm #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 6,
    parameter int FIELD_W  = 6,
    parameter int OPC_W    = 4,
    parameter int OPC_IMM0 = 1,
    parameter int OPC_IMM1 = 2,
    parameter int OPC_REG0 = 3,
    parameter int OPC_CMPI = 4,
    parameter int SIGN_EXT = 0,
    localparam int INSTR_W = OPC_W + 2*FIELD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                pc_inc,
    output logic [NUM_REGS-1:0] rx_out,
    output logic [NUM_REGS-1:0] rx_in,
    output logic                alu_in0,
    output logic                alu_in1,
    output logic                alu_out_latch,
    output logic                alu_out_en,
    output logic                imm_en,
    output logic [DATA_W-1:0]   imm_out
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERR,
        S_FETCH,
        S_LOAD_A,
        S_DRIVE_B,
        S_LOAD_B,
        S_LATCH,
        S_DRIVE_OUT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [OPC_W-1:0]   OP_IMM0 = OPC_W'(OPC_IMM0);
    localparam logic [OPC_W-1:0]   OP_IMM1 = OPC_W'(OPC_IMM1);
    localparam logic [OPC_W-1:0]   OP_REG0 = OPC_W'(OPC_REG0);
    localparam logic [OPC_W-1:0]   OP_CMPI = OPC_W'(OPC_CMPI);
    localparam logic [FIELD_W-1:0] NREG_F  = FIELD_W'(NUM_REGS);
    localparam logic               SX      = (SIGN_EXT != 0);

    state_t               state, next_state;
    logic [INSTR_W-1:0]   instr_q;
    logic                 capture;

    logic [OPC_W-1:0]     in_opc, q_opc;
    logic [FIELD_W-1:0]   in_a, in_b, q_a, q_b;
    logic                 in_valid, in_legal;
    logic                 q_imm, q_cmp;
    logic [NUM_REGS-1:0]  oh_a, oh_b;
    logic [DATA_W-1:0]    ext_b;

    function automatic logic is_imm_class(input logic [OPC_W-1:0] opc);
        return (opc == OP_IMM0) || (opc == OP_IMM1) || (opc == OP_CMPI);
    endfunction

    // Register index 0 selects the MSB of the one-hot enable vector.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [FIELD_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == FIELD_W'(NUM_REGS-1-k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    assign in_opc   = instruction[INSTR_W-1 -: OPC_W];
    assign in_a     = instruction[2*FIELD_W-1 -: FIELD_W];
    assign in_b     = instruction[FIELD_W-1:0];
    assign in_valid = is_imm_class(in_opc) || (in_opc == OP_REG0);
    assign in_legal = (in_a < NREG_F) && ((in_opc != OP_REG0) || (in_b < NREG_F));

    assign q_opc = instr_q[INSTR_W-1 -: OPC_W];
    assign q_a   = instr_q[2*FIELD_W-1 -: FIELD_W];
    assign q_b   = instr_q[FIELD_W-1:0];
    assign q_imm = is_imm_class(q_opc);
    assign q_cmp = (q_opc == OP_CMPI);
    assign oh_a  = onehot(q_a);
    assign oh_b  = onehot(q_b);
    assign ext_b = {{(DATA_W-FIELD_W){q_b[FIELD_W-1] & SX}}, q_b};

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Instruction capture on an accepted start so later bus changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          instr_q <= '0;
        else if (capture) instr_q <= instruction;
    end

    // Next-state decode and Moore strobe generation from state and captured instruction.
    always_comb begin
        next_state    = state;
        capture       = 1'b0;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        err           = 1'b0;
        pc_inc        = 1'b0;
        rx_out        = '0;
        rx_in         = '0;
        alu_in0       = 1'b0;
        alu_in1       = 1'b0;
        alu_out_latch = 1'b0;
        alu_out_en    = 1'b0;
        imm_en        = 1'b0;
        imm_out       = '0;
        case (state)
            S_IDLE: begin
                if (start && !abort && in_valid) begin
                    capture    = 1'b1;
                    next_state = in_legal ? S_FETCH : S_ERR;
                end
            end
            S_ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                pc_inc     = 1'b1;
                next_state = S_IDLE;
            end
            S_FETCH: begin
                pc_inc     = 1'b1;
                rx_out     = oh_a;
                next_state = S_LOAD_A;
            end
            S_LOAD_A: begin
                rx_out     = oh_a;
                alu_in0    = 1'b1;
                next_state = S_DRIVE_B;
            end
            S_DRIVE_B, S_LOAD_B: begin
                if (q_imm) begin
                    imm_en  = 1'b1;
                    imm_out = ext_b;
                end else begin
                    rx_out  = oh_b;
                end
                alu_in1    = (state == S_LOAD_B);
                next_state = (state == S_LOAD_B) ? S_LATCH : S_LOAD_B;
            end
            S_LATCH: begin
                alu_out_latch = 1'b1;
                next_state    = S_DRIVE_OUT;
            end
            S_DRIVE_OUT: begin
                alu_out_en = 1'b1;
                next_state = q_cmp ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                alu_out_en = 1'b1;
                rx_in      = oh_a;
                next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) next_state = S_IDLE;
    end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Scoreboard bench for alu_seq_fsm: expected per-cycle strobe vectors are
// queued when an instruction is issued and popped on every falling edge.
module tb_alu_seq_fsm;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 6;
    localparam int FIELD_W  = 6;
    localparam int OPC_W    = 4;
    localparam int SIGN_EXT = 1;
    localparam int INSTR_W  = OPC_W + 2*FIELD_W;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                err;
        logic                pc_inc;
        logic [NUM_REGS-1:0] rx_out;
        logic [NUM_REGS-1:0] rx_in;
        logic                alu_in0;
        logic                alu_in1;
        logic                alu_out_latch;
        logic                alu_out_en;
        logic                imm_en;
        logic [DATA_W-1:0]   imm_out;
    } outv_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic [INSTR_W-1:0]  instruction;
    logic                busy, done, err, pc_inc;
    logic [NUM_REGS-1:0] rx_out, rx_in;
    logic                alu_in0, alu_in1, alu_out_latch, alu_out_en, imm_en;
    logic [DATA_W-1:0]   imm_out;

    outv_t act;
    outv_t exp_v;
    outv_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    assign act = {busy, done, err, pc_inc, rx_out, rx_in,
                  alu_in0, alu_in1, alu_out_latch, alu_out_en, imm_en, imm_out};

    alu_seq_fsm #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W), .OPC_W(OPC_W),
        .OPC_IMM0(1), .OPC_IMM1(2), .OPC_REG0(3), .OPC_CMPI(4), .SIGN_EXT(SIGN_EXT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .instruction(instruction),
        .busy(busy), .done(done), .err(err), .pc_inc(pc_inc),
        .rx_out(rx_out), .rx_in(rx_in), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out_latch(alu_out_latch), .alu_out_en(alu_out_en),
        .imm_en(imm_en), .imm_out(imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mk(input logic [3:0] opc, input logic [5:0] a, input logic [5:0] b);
        return {opc, a, b};
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endtask

    // Expected vectors for cycles 1..done of an instruction accepted at edge 0.
    task automatic push_instr(input logic [3:0] opc, input logic [5:0] a, input logic [5:0] b);
        outv_t v;
        logic imm_cls, legal;
        logic [NUM_REGS-1:0] oha, ohb;
        logic signed [FIELD_W-1:0] bs;
        logic [DATA_W-1:0] ext;
        imm_cls = (opc == 4'd1) || (opc == 4'd2) || (opc == 4'd4);
        legal   = (a < 6'd6) && ((opc != 4'd3) || (b < 6'd6));
        oha = '0; ohb = '0;
        if (a < 6'd6) oha = NUM_REGS'(1) << (NUM_REGS-1-int'(a));
        if (b < 6'd6) ohb = NUM_REGS'(1) << (NUM_REGS-1-int'(b));
        bs  = b;
        ext = (SIGN_EXT != 0) ? DATA_W'(bs) : DATA_W'(b);
        if (!legal) begin
            v = '0; v.busy = 1; v.done = 1; v.err = 1; v.pc_inc = 1;
            exp_q.push_back(v);
            return;
        end
        v = '0; v.busy = 1; v.pc_inc = 1; v.rx_out = oha;     exp_q.push_back(v);
        v = '0; v.busy = 1; v.alu_in0 = 1; v.rx_out = oha;    exp_q.push_back(v);
        for (int k = 0; k < 2; k++) begin
            v = '0; v.busy = 1; v.alu_in1 = (k == 1);
            if (imm_cls) begin v.imm_en = 1; v.imm_out = ext; end
            else v.rx_out = ohb;
            exp_q.push_back(v);
        end
        v = '0; v.busy = 1; v.alu_out_latch = 1;              exp_q.push_back(v);
        v = '0; v.busy = 1; v.alu_out_en = 1;                 exp_q.push_back(v);
        if (opc != 4'd4) begin
            v = '0; v.busy = 1; v.alu_out_en = 1; v.rx_in = oha; exp_q.push_back(v);
        end
        v = '0; v.busy = 1; v.done = 1;                       exp_q.push_back(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; instruction = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (act !== outv_t'('0)) $display("[TB] FAIL reset_hold: got %h, need %h", act, outv_t'('0));
            else passes++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (act !== outv_t'('0)) $display("[TB] FAIL reset_release: got %h, need %h", act, outv_t'('0));
        else passes++;
    endtask

    task automatic test_issue(input string name, input logic [3:0] opc, input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        instruction = mk(opc, a, b);
        start = 1'b1;
        push_instr(opc, a, b);
        push_idle(2);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            instruction = '1;
            exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("[TB] FAIL %s cycle %0d: got %h, need %h", name, c+1, act, exp_v);
            else passes++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL %s timeout: got %0d left, need 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bad_opcode();
        @(negedge clk);
        instruction = mk(4'd0, 6'd1, 6'd1);
        start = 1'b1;
        push_idle(2);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            start = (c == 0);
            instruction = mk(4'd5, 6'd1, 6'd1);
            exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("[TB] FAIL bad_opcode cycle %0d: got %h, need %h", c+1, act, exp_v);
            else passes++;
        end
        start = 1'b0;
    endtask

    task automatic test_busy_start();
        @(negedge clk);
        instruction = mk(4'd1, 6'd3, 6'd9);
        start = 1'b1;
        push_instr(4'd1, 6'd3, 6'd9);
        push_idle(3);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            start = (c == 4);
            instruction = mk(4'd3, 6'd1, 6'd2);
            exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("[TB] FAIL busy_start cycle %0d: got %h, need %h", c+1, act, exp_v);
            else passes++;
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        instruction = mk(4'd2, 6'd5, 6'd33);
        start = 1'b1;
        push_instr(4'd2, 6'd5, 6'd33);
        push_idle(1);
        push_instr(4'd3, 6'd4, 6'd1);
        push_idle(2);
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            start = (c < 9);
            instruction = mk(4'd3, 6'd4, 6'd1);
            exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("[TB] FAIL back_to_back cycle %0d: got %h, need %h", c+1, act, exp_v);
            else passes++;
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        outv_t tmp[$];
        @(negedge clk);
        instruction = mk(4'd1, 6'd2, 6'd5);
        start = 1'b1;
        push_instr(4'd1, 6'd2, 6'd5);
        tmp = exp_q;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(tmp[i]);
        push_idle(4);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            abort = (c == 3) || (c == 5);
            start = (c == 5);
            exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("[TB] FAIL abort cycle %0d: got %h, need %h", c+1, act, exp_v);
            else passes++;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        outv_t tmp[$];
        @(negedge clk);
        instruction = mk(4'd3, 6'd0, 6'd5);
        start = 1'b1;
        push_instr(4'd3, 6'd0, 6'd5);
        tmp = exp_q;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(tmp[i]);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("[TB] FAIL reset_mid cycle %0d: got %h, need %h", c+1, act, exp_v);
            else passes++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (act !== outv_t'('0)) $display("[TB] FAIL reset_mid immediate: got %h, need %h", act, outv_t'('0));
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (act !== outv_t'('0)) $display("[TB] FAIL reset_mid held: got %h, need %h", act, outv_t'('0));
        else passes++;
        @(negedge clk);
        checks++;
        if (act !== outv_t'('0)) $display("[TB] FAIL reset_mid after: got %h, need %h", act, outv_t'('0));
        else passes++;
    endtask

    initial begin
        test_reset();
        test_issue("imm0",       4'd1, 6'd2, 6'd5);
        test_issue("reg0",       4'd3, 6'd0, 6'd5);
        test_issue("cmpi",       4'd4, 6'd1, 6'h3F);
        test_issue("imm1_ext",   4'd2, 6'd5, 6'h20);
        test_issue("illegal_a7", 4'd2, 6'd7, 6'd1);
        test_issue("illegal_a6", 4'd4, 6'd6, 6'd0);
        test_issue("illegal_b6", 4'd3, 6'd1, 6'd6);
        test_issue("imm_b_big",  4'd1, 6'd0, 6'd40);
        test_bad_opcode();
        test_busy_start();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_fsm.md
Name: alu_seq_fsm

Overview:
- Parametrised ALU instruction sequencer for the microcontroller datapath.
- Decodes one ALU instruction per start pulse, in either register-immediate or register-register form, with optional suppression of the result write-back (compare).
- Drives the shared-bus control strobes: one-hot general-register output/input enables, ALU operand latches, ALU result latch/enable, immediate tri-state enable and PC increment.
- Reports completion with a done/err handshake back to the top-level controller.

Parameters:
DATA_W, 16, datapath/bus width; width of imm_out.
NUM_REGS, 6, number of general registers; width of rx_out/rx_in.
FIELD_W, 6, width of each register/immediate field in the instruction.
OPC_W, 4, opcode width; INSTR_W = OPC_W + 2*FIELD_W.
OPC_IMM0, 1, opcode: reg-immediate with write-back.
OPC_IMM1, 2, opcode: reg-immediate with write-back.
OPC_REG0, 3, opcode: reg-reg with write-back.
OPC_CMPI, 4, opcode: reg-immediate, no write-back.
SIGN_EXT, 0, 1 = sign-extend immediate to DATA_W; 0 = zero-extend.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  synchronous abort to IDLE
instruction  in  INSTR_W  [top OPC_W]=opcode, next FIELD_W=A (src/dest), low FIELD_W=B (imm or src reg)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse, coincident with done, on illegal register index
pc_inc  out  1  PC increment strobe
rx_out  out  NUM_REGS  one-hot register output enable
rx_in  out  NUM_REGS  one-hot register input enable
alu_in0  out  1  latch bus into ALU operand 0
alu_in1  out  1  latch bus into ALU operand 1
alu_out_latch  out  1  latch ALU result
alu_out_en  out  1  drive ALU result onto bus
imm_en  out  1  immediate tri-state enable
imm_out  out  DATA_W  extended immediate; all zeros when imm_en=0

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk. Reset forces IDLE with every output 0.
- Instruction is captured into an internal register on an accepted start. Outputs are Moore, decoded from state plus the captured instruction. Later changes on instruction have no effect.
- Register index i maps to one-hot bit NUM_REGS-1-i (index 0 = MSB).
- An index >= NUM_REGS is illegal. This applies to A for all classes and to B for the reg-reg class.
- start with an opcode outside the four classes is ignored: remain in IDLE, no outputs asserted.
- start while busy is ignored.
- States and outputs (signals not listed are 0):
  IDLE: nothing. start & legal -> FETCH. start & illegal index -> ERR.
  ERR: done=1, err=1, pc_inc=1 (instruction skipped); -> IDLE.
  FETCH: pc_inc=1, rx_out=onehot(A); -> LOAD_A.
  LOAD_A: rx_out=onehot(A), alu_in0=1; -> DRIVE_B.
  DRIVE_B: immediate classes: imm_en=1, imm_out=ext(B). Reg class: rx_out=onehot(B). -> LOAD_B.
  LOAD_B: same drive as DRIVE_B, plus alu_in1=1; -> LATCH.
  LATCH: alu_out_latch=1; -> DRIVE_OUT.
  DRIVE_OUT: alu_out_en=1. CMPI -> DONE; others -> WRITE.
  WRITE: alu_out_en=1, rx_in=onehot(A); -> DONE.
  DONE: done=1; -> IDLE.
- Latency: with start accepted at edge 0, FETCH is occupied in cycle 1 and done is high in cycle 8 (write-back classes) or cycle 7 (CMPI). ERR done is in cycle 1.
- Next start is accepted in the cycle after DONE/ERR; back-to-back throughput is one instruction per 9 cycles.
- ext(B): B is zero-extended to DATA_W, or sign-extended from bit FIELD_W-1 when SIGN_EXT=1.
- rx_out and rx_in are never both nonzero in the same cycle; at most one bus driver per cycle.
- abort in any non-IDLE state -> IDLE on the next edge. Outputs are 0 from that edge, with no done/err. abort takes priority over start in IDLE.
- Reset mid-operation: immediate return to IDLE, outputs 0, no done.

Test Plan:
- NUM_REGS=6, instr {1,A=2,B=5}, start -> cycle1 pc_inc & rx_out=001000; cycle3-4 imm_en, imm_out=0x0005; cycle7 rx_in=001000; cycle8 done=1, busy=0 after.
- Opcode 3, A=0, B=5 -> cycles 3-4 rx_out=000001, imm_en=0; cycle7 rx_in=100000; done cycle8.
- CMPI, A=1, B=6'h3F, SIGN_EXT=1 -> imm_out=0xFFFF; rx_in never nonzero; done cycle7.
- Opcode 2, A=7 -> ERR next cycle: done=err=pc_inc=1, no strobes; IDLE after.
- Opcode 0 with start -> busy stays 0, all outputs 0. start during LATCH -> ignored, single done.
- abort in LOAD_B -> next cycle all outputs 0, busy=0, no done. rst asserted in WRITE -> outputs 0 immediately.
